// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter on the device bus: TX FIFO, control/divisor
// registers, and a shift-register frame FSM with a drained-transmitter interrupt.
module uart_tx_dev #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned FifoDepth    = 8,
    parameter logic [15:0] DefaultDiv   = 16'd16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    err_o,
    output logic                    tx_o,
    output logic                    irq_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]      r_mem [FifoDepth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [LvlW-1:0] r_level;
    state_t          r_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit;
    logic [15:0]     r_bcnt;
    logic [15:0]     r_div_lat;
    logic            r_en;
    logic            r_irq_en;
    logic [15:0]     r_div;
    logic            r_tx;
    logic            r_rvalid;
    logic [DataWidth-1:0] r_rdata;
    logic            r_err;

    logic [11:0]          w_off;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_busy;
    logic                 w_wr;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_start_ok;
    logic [15:0]          w_div_eff;
    logic [DataWidth-1:0] w_rdata;
    logic                 w_err;
    logic                 w_unused;

    assign w_off      = addr_i[11:0];
    assign w_full     = (r_level == LvlW'(FifoDepth));
    assign w_empty    = (r_level == '0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_wr       = req_i & we_i;
    assign w_push_req = w_wr & (w_off == 12'h000) & be_i[0];
    assign w_push     = w_push_req & ~w_full;
    assign w_bit_end  = (r_bcnt == (r_div_lat - 16'd1));
    assign w_start_ok = r_en & ~w_empty;
    assign w_pop      = ((r_state == S_IDLE) & w_start_ok) |
                        ((r_state == S_STOP) & w_bit_end & w_start_ok);
    assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_unused   = ^{addr_i[AddressWidth-1:12], wdata_i[DataWidth-1:16], be_i[3:2]};

    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        case (w_off)
            12'h000: ;
            12'h004: begin
                if (we_i) begin
                    w_err = 1'b1;
                end else begin
                    w_rdata[0]    = w_busy;
                    w_rdata[1]    = w_full;
                    w_rdata[2]    = w_empty;
                    w_rdata[14:8] = 7'(r_level);
                end
            end
            12'h008: if (!we_i) w_rdata[1:0] = {r_irq_en, r_en};
            12'h00C: if (!we_i) w_rdata[15:0] = r_div;
            default: w_err = 1'b1;
        endcase
        // Full is judged before any pop in the same cycle, so the byte is dropped.
        if (w_push_req && w_full) w_err = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= req_i ? w_rdata : '0;
            r_err    <= req_i & w_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_div    <= DefaultDiv;
        end else begin
            if (w_wr && (w_off == 12'h008) && be_i[0]) {r_irq_en, r_en} <= wdata_i[1:0];
            if (w_wr && (w_off == 12'h00C) && be_i[0]) r_div[7:0]  <= wdata_i[7:0];
            if (w_wr && (w_off == 12'h00C) && be_i[1]) r_div[15:8] <= wdata_i[15:8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata_i[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            if (w_push && !w_pop)      r_level <= r_level + LvlW'(1);
            else if (!w_push && w_pop) r_level <= r_level - LvlW'(1);
        end
    end

    // Frame FSM: every state holds its level for r_div_lat clocks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_bcnt    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_div_lat <= 16'd1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state   <= S_START;
                        r_shift   <= r_mem[r_rd_ptr];
                        r_div_lat <= w_div_eff;
                        r_bcnt    <= '0;
                        r_tx      <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_bcnt  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end else begin
                        r_bcnt <= r_bcnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_bcnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_bcnt <= '0;
                        if (w_start_ok) begin
                            r_state   <= S_START;
                            r_shift   <= r_mem[r_rd_ptr];
                            r_div_lat <= w_div_eff;
                            r_tx      <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;
    assign tx_o     = r_tx;
    assign irq_o    = r_irq_en & w_empty & ~w_busy;

endmodule
